// File: rtl/tty_mmio_ctrl.sv
// ---------------------------------------------------------------------------
// tty_mmio_ctrl
//   Memory-mapped TTY handshake sequencer for a core without I/O opcodes.
//   Loads/stores arrive on a chip-select bus. The TX path drives RD and then
//   strobes DSR. The RX path raises CTS, waits for RTS, and then lets a
//   counted settle window run before it latches TD.
//
//   Build option: define TTY_IRQ_EN to enable irq_o and CTRL[2:1].
//
// State table (TX)
//   TX_IDLE     | no character in flight, accepts DATA store
//   TX_SETUP    | RD stable, counting SETUP_CYC before strobe
//   TX_WAIT_DTR | waiting for synchronised DTR
//   TX_STROBE   | DSR high for STROBE_CYC cycles
//   TX_HOLD     | DSR low, RD held one more cycle
// State table (RX)
//   RX_ARM      | CTS offered (when rx_en and buffer empty)
//   RX_SETTLE   | RTS seen, counting SETTLE_CYC before TD capture
//   RX_FULL     | character in rx_buf, waiting for DATA load
//
// Ports
//   ck, clr_n          clock / async active-low reset
//   cs_i, we_i, re_i   bus chip select, store strobe, load strobe
//   addr_i             0 DATA, 1 STATUS, 2 CTRL, 3 reserved
//   wdata_i / rdata_o  store data / registered load data
//   tty_td_i           character from terminal
//   tty_rts_i          terminal has data (async)
//   tty_dtr_i          terminal ready (async)
//   tty_rd_o           character to terminal
//   tty_cts_o          ready to receive
//   tty_dsr_o          character-valid strobe
//   irq_o              interrupt request (TTY_IRQ_EN only)
// ---------------------------------------------------------------------------
module tty_mmio_ctrl #(
  parameter int unsigned SETUP_CYC  = 4,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned SETTLE_CYC = 12   // terminal needs at least 10
) (
  input  logic        ck,
  input  logic        clr_n,
  input  logic        cs_i,
  input  logic        we_i,
  input  logic        re_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  input  logic [7:0]  tty_td_i,
  input  logic        tty_rts_i,
  input  logic        tty_dtr_i,
  output logic [7:0]  tty_rd_o,
  output logic        tty_cts_o,
  output logic        tty_dsr_o,
  output logic        irq_o
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_STAT = 2'd1;
  localparam logic [1:0] A_CTRL = 2'd2;

  typedef enum logic [2:0] {
    TX_IDLE, TX_SETUP, TX_WAIT_DTR, TX_STROBE, TX_HOLD
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_ARM, RX_SETTLE, RX_FULL
  } rx_state_e;

  // synchronisers
  logic [1:0] rts_sync_q;
  logic       rts_dly_q;
  logic [1:0] dtr_sync_q;
  logic       rts_rise;
  logic       dtr_sync;

  tx_state_e        tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [7:0]       rd_q, rd_d;
  logic             dsr_q, dsr_d;
  logic             tx_ovr_q, tx_ovr_d;

  rx_state_e        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [7:0]       rx_buf_q, rx_buf_d;
  logic             rx_valid_q, rx_valid_d;
  logic             rx_ovr_q, rx_ovr_d;

  logic [2:0]       ctrl_q, ctrl_d;
  logic [31:0]      rdata_q, rdata_d;

  logic bus_wr, bus_rd;
  logic data_wr, data_rd, stat_rd, ctrl_wr;
  logic tx_busy;
  logic [4:0] status;

  logic unused_wdata;
  assign unused_wdata = ^wdata_i[31:8];

  assign bus_wr  = cs_i & we_i;
  assign bus_rd  = cs_i & re_i;
  assign data_wr = bus_wr & (addr_i == A_DATA);
  assign data_rd = bus_rd & (addr_i == A_DATA);
  assign stat_rd = bus_rd & (addr_i == A_STAT);
  assign ctrl_wr = bus_wr & (addr_i == A_CTRL);

  assign rts_rise = rts_sync_q[1] & ~rts_dly_q;
  assign dtr_sync = dtr_sync_q[1];
  assign tx_busy  = (tx_state_q != TX_IDLE);
  assign status   = {rx_ovr_q, tx_ovr_q, dtr_sync, rx_valid_q, tx_busy};

  // ---------------- TX next state ----------------
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    rd_d       = rd_q;
    tx_ovr_d   = tx_ovr_q & ~stat_rd;
    unique case (tx_state_q)
      TX_IDLE: begin
        if (data_wr) begin
          rd_d       = wdata_i[7:0];
          tx_cnt_d   = SETUP_LD;
          tx_state_d = TX_SETUP;
        end
      end
      TX_SETUP: begin
        if (tx_cnt_q == '0) tx_state_d = TX_WAIT_DTR;
        else                tx_cnt_d   = tx_cnt_q - 1'b1;
      end
      TX_WAIT_DTR: begin
        if (dtr_sync) begin
          tx_cnt_d   = STROBE_LD;
          tx_state_d = TX_STROBE;
        end
      end
      TX_STROBE: begin
        if (tx_cnt_q == '0) tx_state_d = TX_HOLD;
        else                tx_cnt_d   = tx_cnt_q - 1'b1;
      end
      TX_HOLD:  tx_state_d = TX_IDLE;
      default:  tx_state_d = TX_IDLE;
    endcase
    // overrun set takes priority over a same-cycle STATUS read clear
    if (data_wr && tx_busy) tx_ovr_d = 1'b1;
  end

  // DSR is a flop so it is glitch-free and still clears asynchronously
  assign dsr_d = (tx_state_d == TX_STROBE);

  // ---------------- RX next state ----------------
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_buf_d   = rx_buf_q;
    rx_valid_d = rx_valid_q;
    rx_ovr_d   = rx_ovr_q & ~stat_rd;
    unique case (rx_state_q)
      RX_ARM: begin
        if (rts_rise) begin
          rx_cnt_d   = SETTLE_LD;
          rx_state_d = RX_SETTLE;
        end
      end
      RX_SETTLE: begin
        // runs to completion even if rx_en is cleared meanwhile
        if (rx_cnt_q == '0) begin
          rx_buf_d   = tty_td_i;
          rx_valid_d = 1'b1;
          rx_state_d = RX_FULL;
        end else begin
          rx_cnt_d = rx_cnt_q - 1'b1;
        end
      end
      RX_FULL: begin
        if (data_rd) begin
          rx_valid_d = 1'b0;
          rx_state_d = RX_ARM;
        end
      end
      default: rx_state_d = RX_ARM;
    endcase
    if (rts_rise && (rx_state_q != RX_ARM)) rx_ovr_d = 1'b1;
  end

  // ---------------- register file ----------------
  always_comb begin
    ctrl_d = ctrl_q;
    if (ctrl_wr) begin
`ifdef TTY_IRQ_EN
      ctrl_d = wdata_i[2:0];
`else
      ctrl_d = {2'b00, wdata_i[0]};
`endif
    end
  end

  // DATA load returns the pre-edge rx_buf, so a same-cycle capture is not lost
  always_comb begin
    rdata_d = rdata_q;
    if (bus_rd) begin
      unique case (addr_i)
        A_DATA:  rdata_d = {24'd0, rx_buf_q};
        A_STAT:  rdata_d = {27'd0, status};
        A_CTRL:  rdata_d = {29'd0, ctrl_q};
        default: rdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge ck or negedge clr_n) begin
    if (!clr_n) begin
      rts_sync_q <= '0;
      rts_dly_q  <= 1'b0;
      dtr_sync_q <= '0;
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      rd_q       <= '0;
      dsr_q      <= 1'b0;
      tx_ovr_q   <= 1'b0;
      rx_state_q <= RX_ARM;
      rx_cnt_q   <= '0;
      rx_buf_q   <= '0;
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
      ctrl_q     <= '0;
      rdata_q    <= '0;
    end else begin
      rts_sync_q <= {rts_sync_q[0], tty_rts_i};
      rts_dly_q  <= rts_sync_q[1];
      dtr_sync_q <= {dtr_sync_q[0], tty_dtr_i};
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      rd_q       <= rd_d;
      dsr_q      <= dsr_d;
      tx_ovr_q   <= tx_ovr_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_buf_q   <= rx_buf_d;
      rx_valid_q <= rx_valid_d;
      rx_ovr_q   <= rx_ovr_d;
      ctrl_q     <= ctrl_d;
      rdata_q    <= rdata_d;
    end
  end

`ifdef TTY_IRQ_EN
  logic irq_q, irq_d;
  assign irq_d = (ctrl_q[1] & rx_valid_q) | (ctrl_q[2] & ~tx_busy);
  always_ff @(posedge ck or negedge clr_n) begin
    if (!clr_n) irq_q <= 1'b0;
    else        irq_q <= irq_d;
  end
  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

  assign rdata_o   = rdata_q;
  assign tty_rd_o  = rd_q;
  assign tty_dsr_o = dsr_q;
  assign tty_cts_o = (rx_state_q == RX_ARM) & ctrl_q[0] & ~rx_valid_q;

endmodule

// File: tb/tb_tty_mmio_ctrl.sv
module tb_tty_mmio_ctrl;

  logic        ck = 1'b0;
  logic        clr_n;
  logic        cs_i, we_i, re_i;
  logic [1:0]  addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic [7:0]  tty_td_i;
  logic        tty_rts_i, tty_dtr_i;
  logic [7:0]  tty_rd_o;
  logic        tty_cts_o, tty_dsr_o, irq_o;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];
  logic        rd_pend = 1'b0;

`ifdef TTY_IRQ_EN
  localparam logic [31:0] CTRL7_RB = 32'h7;
  localparam logic        IRQ_EXP  = 1'b1;
`else
  localparam logic [31:0] CTRL7_RB = 32'h1;
  localparam logic        IRQ_EXP  = 1'b0;
`endif

  tty_mmio_ctrl dut (
    .ck        (ck),
    .clr_n     (clr_n),
    .cs_i      (cs_i),
    .we_i      (we_i),
    .re_i      (re_i),
    .addr_i    (addr_i),
    .wdata_i   (wdata_i),
    .rdata_o   (rdata_o),
    .tty_td_i  (tty_td_i),
    .tty_rts_i (tty_rts_i),
    .tty_dtr_i (tty_dtr_i),
    .tty_rd_o  (tty_rd_o),
    .tty_cts_o (tty_cts_o),
    .tty_dsr_o (tty_dsr_o),
    .irq_o     (irq_o)
  );

  always #5 ck = ~ck;

  // scoreboard monitor: a load issued on one edge presents rdata by the next negedge
  always @(posedge ck) rd_pend <= cs_i & re_i;

  always @(negedge ck) begin
    if (rd_pend) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rdata_unexpected got=%h expected=<none queued>", rdata_o);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (rdata_o !== e) begin
          errors++;
          $display("FAIL rdata got=%h expected=%h", rdata_o, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge ck);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cs_i = 1'b1; we_i = 1'b1; addr_i = a; wdata_i = d;
    @(negedge ck);
    cs_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] e);
    cs_i = 1'b1; re_i = 1'b1; addr_i = a;
    exp_q.push_back(e);
    @(negedge ck);
    cs_i = 1'b0; re_i = 1'b0;
  endtask

  initial begin
    clr_n = 1'b0; cs_i = 1'b0; we_i = 1'b0; re_i = 1'b0;
    addr_i = 2'd0; wdata_i = 32'd0; tty_td_i = 8'd0;
    tty_rts_i = 1'b0; tty_dtr_i = 1'b1;
    tick(2);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_rd",    {24'd0, tty_rd_o}, 32'd0);
    chk("rst_cts",   {31'd0, tty_cts_o}, 32'd0);
    chk("rst_dsr",   {31'd0, tty_dsr_o}, 32'd0);
    chk("rst_irq",   {31'd0, irq_o}, 32'd0);
    clr_n = 1'b1;
    tick(4);

    // TX timing with DTR already high
    wr(2'd0, 32'h41);
    chk("t1_rd", {24'd0, tty_rd_o}, 32'h41);
    for (int k = 1; k <= 7; k++) begin
      chk("t1_dsr", {31'd0, tty_dsr_o}, {31'd0, (k >= 6)});
      @(negedge ck);
    end
    chk("t1_dsr_fall", {31'd0, tty_dsr_o}, 32'd0);
    rd(2'd1, 32'h05);
    rd(2'd1, 32'h04);

    // RX capture with settle window
    wr(2'd2, 32'h1);
    chk("t2_cts_on", {31'd0, tty_cts_o}, 32'd1);
    tty_td_i = 8'h61; tty_rts_i = 1'b1;
    tick(2);
    chk("t2_cts_pre", {31'd0, tty_cts_o}, 32'd1);
    tick(1);
    chk("t2_cts_drop", {31'd0, tty_cts_o}, 32'd0);
    tty_rts_i = 1'b0;
    tick(11);
    rd(2'd1, 32'h04);
    rd(2'd1, 32'h06);
    rd(2'd0, 32'h61);
    chk("t2_cts_back", {31'd0, tty_cts_o}, 32'd1);

    // store while busy: ignored, sticky overrun cleared by STATUS load
    tty_dtr_i = 1'b0;
    tick(4);
    wr(2'd0, 32'h41);
    tick(2);
    wr(2'd0, 32'h42);
    chk("t3_rd_keep", {24'd0, tty_rd_o}, 32'h41);
    rd(2'd1, 32'h09);
    rd(2'd1, 32'h01);
    tty_dtr_i = 1'b1;
    tick(12);
    rd(2'd1, 32'h04);

    // park in WAIT_DTR, release by DTR
    tty_dtr_i = 1'b0;
    tick(4);
    wr(2'd0, 32'h55);
    tick(10);
    chk("t5_rd", {24'd0, tty_rd_o}, 32'h55);
    chk("t5_dsr_park", {31'd0, tty_dsr_o}, 32'd0);
    tty_dtr_i = 1'b1;
    tick(2);
    chk("t5_dsr_wait", {31'd0, tty_dsr_o}, 32'd0);
    tick(1);
    chk("t5_dsr_rise", {31'd0, tty_dsr_o}, 32'd1);
    tick(6);

    // RX overrun while buffer full
    tty_td_i = 8'h33; tty_rts_i = 1'b1;
    tick(4);
    tty_rts_i = 1'b0;
    tick(16);
    tty_td_i = 8'h77; tty_rts_i = 1'b1;
    tick(4);
    tty_rts_i = 1'b0;
    tick(4);
    rd(2'd1, 32'h16);
    rd(2'd0, 32'h33);
    rd(2'd1, 32'h04);

    // CTRL width, irq, reserved address
    wr(2'd2, 32'h7);
    tick(1);
    chk("irq", {31'd0, irq_o}, {31'd0, IRQ_EXP});
    rd(2'd2, CTRL7_RB);
    wr(2'd3, 32'hFF);
    rd(2'd3, 32'h0);
    wr(2'd2, 32'h1);

    // reset in the middle of the strobe
    wr(2'd0, 32'h5A);
    tick(5);
    chk("t6_dsr_pre", {31'd0, tty_dsr_o}, 32'd1);
    #2 clr_n = 1'b0;
    #1;
    chk("t6_dsr_async", {31'd0, tty_dsr_o}, 32'd0);
    chk("t6_cts", {31'd0, tty_cts_o}, 32'd0);
    chk("t6_irq", {31'd0, irq_o}, 32'd0);
    chk("t6_rd", {24'd0, tty_rd_o}, 32'd0);
    chk("t6_rdata", rdata_o, 32'd0);
    @(negedge ck);
    clr_n = 1'b1;
    rd(2'd1, 32'h0);
    rd(2'd2, 32'h0);
    chk("t6_cts_after", {31'd0, tty_cts_o}, 32'd0);
    tick(2);
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
